// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared state encoding and sizing helper for the UART TX scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  function automatic int grant_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
// ============================================================================
// uart_tx_sched_if : requester handshake plus transmitter control bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_sched_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_byte;
  logic                 tx_busy;
  logic                 tx_done;
  logic [GRANT_W-1:0]   grant_id;
  logic                 sched_busy;

  modport master (
    output req_valid, req_byte, req_last, tx_busy, tx_done,
    input  req_ready, tx_valid, tx_byte, grant_id, sched_busy
  );

  modport slave (
    input  req_valid, req_byte, req_last, tx_busy, tx_done,
    output req_ready, tx_valid, tx_byte, grant_id, sched_busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
// uart_rr_pick : combinational round-robin pick starting after the last grant
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [GRANT_W-1:0] i_last,
  output logic      [GRANT_W-1:0] o_pick,
  output logic                    o_any
);

  // Scan farthest-first so the nearest set bit after i_last wins.
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [GRANT_W-1:0] w_idx;
      w_idx = GRANT_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_pick = w_idx;
        o_any  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : 8N1 serializer, latches a byte only while idle, one-cycle done
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic       i_data_valid,
  input  wire logic [7:0] i_byte,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_tx
);

  logic [9:0]  r_shift;
  logic [3:0]  r_bit;
  logic [15:0] r_clk;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '1;
      r_bit   <= '0;
      r_clk   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_data_valid) begin
          r_shift <= {1'b1, i_byte, 1'b0};
          r_bit   <= '0;
          r_clk   <= '0;
          r_busy  <= 1'b1;
        end
      end else if (r_clk == 16'(CLKS_PER_BIT - 1)) begin
        r_clk   <= '0;
        r_shift <= {1'b1, r_shift[9:1]};
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
        end
      end else begin
        r_clk <= r_clk + 16'd1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_tx   = r_busy ? r_shift[0] : 1'b1;

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// uart_tx_sched : round-robin sharing of one uart_tx among NUM_REQ producers,
//                 with optional packet lock and lock timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_EN      = 1,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  uart_tx_sched_if.slave bus
);

  localparam int          GRANT_W   = grant_w(NUM_REQ);
  localparam logic [15:0] c_TO_LAST = (LOCK_TIMEOUT <= 1) ? 16'd0 : 16'(LOCK_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nx;
  logic [7:0]           r_tx_byte;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_last_grant;
  logic                 r_lock_end;
  logic                 r_done_q;
  logic [15:0]          r_cnt;

  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_take;
  logic [GRANT_W-1:0]   w_sel;
  logic [GRANT_W-1:0]   w_pick;
  logic                 w_any;
  logic                 w_done_rise;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last_grant),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  assign w_done_rise = bus.tx_done & ~r_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_ready    = '0;
    w_take     = 1'b0;
    w_sel      = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_ready[w_pick] = 1'b1;
          w_take          = 1'b1;
          w_sel           = w_pick;
          w_state_nx      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.tx_busy) w_state_nx = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_done_rise)
          w_state_nx = ((LOCK_EN != 0) && !r_lock_end) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (bus.req_valid[r_grant]) begin
          w_ready[r_grant] = 1'b1;
          w_take           = 1'b1;
          w_state_nx       = ST_ISSUE;
        end else if (r_cnt == c_TO_LAST) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_byte    <= '0;
      r_grant      <= '0;
      r_last_grant <= GRANT_W'(NUM_REQ - 1);
      r_lock_end   <= 1'b0;
      r_done_q     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_done_q <= bus.tx_done;
      if (w_take) begin
        r_tx_byte    <= bus.req_byte[{w_sel, 3'b000} +: 8];
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_lock_end   <= bus.req_last[w_sel];
      end
      // Counter only runs while waiting in HOLD; any other state re-arms it.
      if (r_state != ST_HOLD)  r_cnt <= '0;
      else if (!w_take)        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.tx_valid   = (r_state == ST_ISSUE);
  assign bus.tx_byte    = r_tx_byte;
  assign bus.grant_id   = r_grant;
  assign bus.sched_busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// tb_uart_tx_sched : scheduler + uart_tx with serial-line monitor and scoreboard
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int GRANT_W = 2;
  localparam int CPB     = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic tx_rst_n;
  logic stretch;
  logic r_done_d = 1'b0;
  logic w_done_raw;
  logic w_line;
  int   cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] rq [NUM_REQ][$];
  logic [7:0] exp_q [$];

  int viol_hot = 0, viol_busy = 0, rdy2_cnt = 0, vrise = 0, done_rise_cyc = 0;
  logic prev_valid = 1'b0, prev_done = 1'b0;

  uart_tx_sched_if #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) bus ();

  uart_tx_sched #(
    .NUM_REQ      (NUM_REQ),
    .LOCK_EN      (1),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  uart_tx #(.CLKS_PER_BIT(CPB)) u_tx (
    .clk          (clk),
    .reset_n      (tx_rst_n),
    .i_data_valid (bus.tx_valid),
    .i_byte       (bus.tx_byte),
    .o_busy       (bus.tx_busy),
    .o_done       (w_done_raw),
    .o_tx         (w_line)
  );

  assign bus.tx_done = w_done_raw | (stretch & r_done_d);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_done_d <= w_done_raw;
    cyc      <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if ($countones(bus.req_ready) > 1) viol_hot++;
    if ((bus.req_ready != '0) && bus.tx_busy) viol_busy++;
    if (bus.req_ready[2]) rdy2_cnt++;
    if (bus.tx_valid && !prev_valid) vrise++;
    if (bus.tx_done && !prev_done) done_rise_cyc = cyc;
    prev_valid = bus.tx_valid;
    prev_done  = bus.tx_done;
  end

  task automatic drive();
    bus.req_valid = '0;
    bus.req_byte  = '0;
    bus.req_last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_byte[8*i +: 8]  = rq[i][0][7:0];
        bus.req_last[i]         = rq[i][0][8];
      end
    end
  endtask

  // Requester model: pops a byte after every edge where it saw ready&valid.
  initial begin
    logic [NUM_REQ-1:0] take;
    drive();
    forever begin
      @(negedge clk);
      take = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (take[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      drive();
    end
  end

  // Serial-line monitor, samples mid-bit and scores against exp_q.
  initial begin
    logic [7:0] b;
    logic       stop;
    forever begin
      @(negedge clk);
      if (w_line == 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = w_line;
        end
        repeat (CPB) @(negedge clk);
        stop = w_line;
        chk("stop_bit", 32'(stop), 32'd1);
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
        else                   chk("wire_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic enq(input int id, input logic [7:0] b, input logic l);
    rq[id].push_back({l, b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    repeat (3) @(negedge clk);
    while (!ok && n < 2000) begin
      ok = (exp_q.size() == 0) && !bus.sched_busy && all_empty();
      if (!ok) begin
        @(negedge clk);
        n++;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int snap, n, rc;
    reset_n  = 1'b0;
    tx_rst_n = 1'b0;
    stretch  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
    chk("rst_tx_byte",    32'(bus.tx_byte),    32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    chk("rst_grant_id",   32'(bus.grant_id),   32'd0);
    chk("rst_sched_busy", 32'(bus.sched_busy), 32'd0);
    reset_n  = 1'b1;
    tx_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester
    snap = rdy2_cnt;
    enq(2, 8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    wait_idle("t1_idle");
    chk("t1_ready2_cycles", 32'(rdy2_cnt - snap), 32'd1);
    chk("t1_grant_id",      32'(bus.grant_id),    32'd2);
    chk("t1_sched_busy",    32'(bus.sched_busy),  32'd0);

    // Round robin between 0 and 1
    enq(0, 8'h11, 1'b1); enq(0, 8'h11, 1'b1);
    enq(1, 8'h22, 1'b1); enq(1, 8'h22, 1'b1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    wait_idle("t2_idle");
    chk("t2_ready_while_busy", 32'(viol_busy), 32'd0);
    chk("t2_onehot_ready",     32'(viol_hot),  32'd0);

    // Locked packet from requester 1 while requester 0 waits
    enq(1, 8'h31, 1'b0); enq(1, 8'h32, 1'b0); enq(1, 8'h33, 1'b1);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h05);
    n = 0;
    while (rq[1].size() > 2 && n < 200) begin @(negedge clk); n++; end
    chk("t3_first_taken", 32'(rq[1].size()), 32'd2);
    enq(0, 8'h05, 1'b1);
    wait_idle("t3_idle");

    // Lock timeout
    enq(3, 8'h40, 1'b0);
    exp_q.push_back(8'h40); exp_q.push_back(8'h06);
    n = 0;
    while (rq[3].size() > 0 && n < 200) begin @(negedge clk); n++; end
    enq(0, 8'h06, 1'b1);
    n = 0;
    while (!bus.req_ready[0] && n < 600) begin @(negedge clk); n++; end
    rc = cyc;
    chk("t4_ready0_seen", 32'(bus.req_ready[0]), 32'd1);
    chk("t4_timeout_gap", 32'(rc - done_rise_cyc), 32'd9);
    wait_idle("t4_idle");

    // Long done pulse
    stretch = 1'b1;
    snap = vrise;
    enq(2, 8'h55, 1'b1); enq(2, 8'h66, 1'b1);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    wait_idle("t5_idle");
    repeat (20) @(negedge clk);
    chk("t5_tx_valid_rises", 32'(vrise - snap), 32'd2);
    stretch = 1'b0;

    // Reset during a data bit
    enq(1, 8'h77, 1'b1);
    exp_q.push_back(8'h77);
    n = 0;
    while (!bus.tx_busy && n < 200) begin @(negedge clk); n++; end
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid",   32'(bus.tx_valid),   32'd0);
    chk("mid_rst_tx_byte",    32'(bus.tx_byte),    32'd0);
    chk("mid_rst_req_ready",  32'(bus.req_ready),  32'd0);
    chk("mid_rst_grant_id",   32'(bus.grant_id),   32'd0);
    chk("mid_rst_sched_busy", 32'(bus.sched_busy), 32'd0);
    n = 0;
    while (bus.tx_busy && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    enq(3, 8'h88, 1'b1); enq(0, 8'h99, 1'b1);
    exp_q.push_back(8'h99); exp_q.push_back(8'h88);
    n = 0;
    while (bus.req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    chk("t6_first_after_reset", 32'(bus.req_ready), 32'd1);
    wait_idle("t6_idle");

    repeat (20) @(negedge clk);
    chk("final_exp_drained", 32'(exp_q.size()), 32'd0);
    chk("final_onehot_ready", 32'(viol_hot), 32'd0);
    chk("final_ready_while_busy", 32'(viol_busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing the single `uart_tx` serializer among NUM_REQ byte producers (debug console, register dump, link status). Each producer offers bytes over a valid/ready handshake. The scheduler picks one requester, hands its byte to the transmitter, and waits for serialization to complete before granting again. An optional packet lock keeps a multi-byte message from one requester contiguous on the wire.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `LOCK_EN`, 1: 1 = grant held from first byte until a byte with `req_last` set; 0 = re-arbitrate after every byte.
- `LOCK_TIMEOUT`, 65535: cycles to wait in HOLD for the locked requester before releasing the lock; 16-bit counter.
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous active-low reset; deassertion is synchronous to `clk` at the source.
- `req_valid`  in  NUM_REQ  requester i has a byte offered.
- `req_byte`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  offered byte ends requester i's packet.
- `req_ready`  out  NUM_REQ  requester i's byte is taken on this edge.
- `tx_valid`  out  1  to `uart_tx.data_valid`.
- `tx_byte`  out  8  to `uart_tx.byte`.
- `tx_busy`  in  1  from `uart_tx.busy`.
- `tx_done`  in  1  from `uart_tx.done`; may stay high for more than one cycle.
- `grant_id`  out  clog2(NUM_REQ)  current or last owner.
- `sched_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, HOLD.
- **IDLE:**
  - If any `req_valid` is set, pick the first set bit scanning from `last_grant+1` with modulo wrap.
  - `req_ready[pick]` is high combinationally in the same cycle.
  - On the edge: capture the byte into `tx_byte`, set `grant_id`/`last_grant` to pick, latch `req_last[pick]` into `lock_end`, go to ISSUE.
- **ISSUE:**
  - `tx_valid` is 1 and is held until `tx_busy` is sampled 1. Holding is harmless because the transmitter latches only in its idle state.
  - When `tx_busy` is sampled 1: drop `tx_valid`, go to WAIT_DONE.
- **WAIT_DONE:**
  - Act only on the rising edge of `tx_done` (0 in the previous cycle, 1 in this one), using a registered `done_q`. A long `done` pulse counts once.
  - On that edge: if `LOCK_EN` and not `lock_end`, go to HOLD with the timeout counter cleared; else go to IDLE.
- **HOLD:**
  - Only `req_ready[grant_id]` may assert, combinationally, when `req_valid[grant_id]` is high.
  - On transfer: capture the byte and `lock_end`, go to ISSUE.
  - Otherwise the counter increments. At `LOCK_TIMEOUT-1` the scheduler goes to IDLE.
  - Other requesters never get ready while in HOLD.
- At most one `req_ready` bit is high in any cycle. `req_ready` is 0 in ISSUE and WAIT_DONE.
- `req_byte`/`req_last` of non-selected requesters are ignored.

## Timing
- Reset values:
  - Outputs: `tx_valid`=0, `tx_byte`=0, `req_ready`=0, `grant_id`=0, `sched_busy`=0.
  - Internal: `last_grant`=NUM_REQ-1, so requester 0 wins first; `done_q`=0, state IDLE, timeout counter 0.
- Request to wire: the transfer edge is cycle 0. `tx_valid`=1 from cycle 1. The transmitter accepts at cycle 1. `tx_busy`=1 at cycle 2. `tx_valid`=0 from cycle 3.
- Back-to-back: the next `req_ready` is possible in the cycle after the scheduler registers the `tx_done` rising edge (state IDLE or HOLD). `tx_valid` re-rises one cycle later, by which point the transmitter is idle again.
- Simultaneous requests in IDLE: only the rotation winner gets ready. The others stay pending with no loss.
- A requester dropping `req_valid` without a transfer is legal and has no effect.
- Reset mid-operation (any state): all outputs return to reset values immediately (asynchronous). The captured byte is discarded and the lock is cleared. The transmitter is not reset by this block.
- `LOCK_TIMEOUT` = 0 is treated as 1.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2, HOLD=2'd3);
  - `GRANT_W` = clog2 helper.
- One sub-module: `uart_rr_pick`, combinational. Inputs: request vector, `last_grant`. Outputs: `pick` index, `any`.
- Top level holds the FSM, byte/lock registers, `done_q` edge detect, and the timeout counter.
- Bench instantiates `uart_tx` with CLKS_PER_BIT=4 and a serial-line monitor.

## Test plan
- Single requester 2 sends 0xA5 (`req_last`=1) → `req_ready[2]` for one cycle; line carries start, 1010_0101 LSB first, stop; `grant_id`=2; state returns to IDLE.
- Requesters 0 and 1 both offer (0x11, 0x22) continuously from reset, LOCK_EN=0 → wire order 0x11, 0x22, 0x11, 0x22; no `req_ready` while `tx_busy`.
- LOCK_EN=1: requester 1 sends 0x31, 0x32, 0x33 (last on 0x33) while requester 0 also requests → wire 0x31 0x32 0x33 then requester 0's byte.
- Lock timeout, LOCK_TIMEOUT=8: requester 3 sends 0x40 (`req_last`=0) then goes silent, requester 0 waiting → requester 0 gets `req_ready` 8 cycles after HOLD entry.
- Transmitter `done` held 2 cycles → exactly one byte per request, no duplicate `tx_valid`.
- `reset_n` low mid data bit → outputs zero same cycle; after release, requester 0 has first priority.
